// File: rtl/alu_pkg.sv
// Shared opcode encoding, FSM state type and default width for the ALU execution path.
package alu_pkg;

  localparam int unsigned AluWidth = 32;

  // Opcodes also produced by the ALU control decoder; keep both sides in sync.
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_SLT  = 3'b100;
  localparam logic [2:0] ALU_DIV  = 3'b101;
  localparam logic [2:0] ALU_NOP  = 3'b110;
  localparam logic [2:0] ALU_MULT = 3'b111;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix
  } alu_state_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Unsigned magnitude core: one shift-add (multiply) or restoring shift-subtract (divide)
// step per cycle for Width cycles after a go pulse.
module alu_muldiv_iter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             go_i,
  input  logic             is_div_i,
  input  logic [Width-1:0] mag_a_i,
  input  logic [Width-1:0] mag_b_i,
  output logic             finish_o,
  output logic [Width-1:0] hi_o,
  output logic [Width-1:0] lo_o
);

  localparam int unsigned CntW = $clog2(Width);
  localparam logic [CntW-1:0] LastCnt = CntW'(Width - 1);

  logic [Width-1:0] acc_q, acc_d;
  logic [Width-1:0] sh_q, sh_d;
  logic [Width-1:0] m_q, m_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             run_q, run_d;
  logic             div_q, div_d;

  logic [Width:0] add_sum;
  logic [Width:0] rem_sh;
  logic [Width:0] sub_diff;

  always_comb begin
    add_sum  = {1'b0, acc_q} + (sh_q[0] ? {1'b0, m_q} : '0);
    rem_sh   = {acc_q, sh_q[Width-1]};
    sub_diff = rem_sh - {1'b0, m_q};

    acc_d = acc_q;
    sh_d  = sh_q;
    m_d   = m_q;
    cnt_d = cnt_q;
    run_d = run_q;
    div_d = div_q;

    if (go_i) begin
      acc_d = '0;
      sh_d  = mag_a_i;
      m_d   = mag_b_i;
      cnt_d = '0;
      run_d = 1'b1;
      div_d = is_div_i;
    end else if (run_q) begin
      if (div_q) begin
        // Remainder stays below the divisor, so the shifted value fits Width+1 bits.
        if (!sub_diff[Width]) begin
          acc_d = sub_diff[Width-1:0];
          sh_d  = {sh_q[Width-2:0], 1'b1};
        end else begin
          acc_d = rem_sh[Width-1:0];
          sh_d  = {sh_q[Width-2:0], 1'b0};
        end
      end else begin
        acc_d = add_sum[Width:1];
        sh_d  = {add_sum[0], sh_q[Width-1:1]};
      end
      if (cnt_q == LastCnt) begin
        run_d = 1'b0;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
      sh_q  <= '0;
      m_q   <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
      div_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      sh_q  <= sh_d;
      m_q   <= m_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
      div_q <= div_d;
    end
  end

  assign finish_o = run_q && (cnt_q == LastCnt);
  assign hi_o     = acc_q;
  assign lo_o     = sh_q;

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: single-cycle logic/arith ops plus iterative signed MULT/DIV into HI/LO,
// with a start/busy/done handshake for pipeline stalls.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = AluWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       ALU_aluOp,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  alu_state_e state_q, state_d;

  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
  logic             sa_q, sa_d;
  logic             neg_q, neg_d;
  logic             div_q, div_d;

  logic               go;
  logic               core_finish;
  logic [WIDTH-1:0]   core_hi, core_lo;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_wr;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Magnitude of the most-negative value is 2^(WIDTH-1), still exact as unsigned.
  assign mag_a = a[WIDTH-1] ? -a : a;
  assign mag_b = b[WIDTH-1] ? -b : b;

  alu_muldiv_iter #(
    .Width (WIDTH)
  ) u_muldiv_iter (
    .clk_i    (clk),
    .rst_i    (rst),
    .go_i     (go),
    .is_div_i (ALU_aluOp == ALU_DIV),
    .mag_a_i  (mag_a),
    .mag_b_i  (mag_b),
    .finish_o (core_finish),
    .hi_o     (core_hi),
    .lo_o     (core_lo)
  );

  always_comb begin
    prod_fix = neg_q ? -{core_hi, core_lo} : {core_hi, core_lo};
    quo_fix  = neg_q ? -core_lo : core_lo;
    rem_fix  = sa_q ? -core_hi : core_hi;

    alu_res = '0;
    alu_wr  = 1'b0;
    go      = 1'b0;

    state_d  = state_q;
    result_d = result_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    dz_d     = dz_q;
    sa_d     = sa_q;
    neg_d    = neg_q;
    div_d    = div_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          done_d = 1'b1;
          dz_d   = 1'b0;
          case (ALU_aluOp)
            ALU_AND: begin alu_res = a & b; alu_wr = 1'b1; end
            ALU_OR:  begin alu_res = a | b; alu_wr = 1'b1; end
            ALU_ADD: begin alu_res = a + b; alu_wr = 1'b1; end
            ALU_SUB: begin alu_res = a - b; alu_wr = 1'b1; end
            ALU_SLT: begin
              alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
              alu_wr  = 1'b1;
            end
            ALU_NOP: ;
            default: begin
              if (ALU_aluOp == ALU_DIV && b == '0) begin
                result_d = '1;
                lo_d     = '1;
                hi_d     = a;
                zero_d   = 1'b0;
                dz_d     = 1'b1;
              end else begin
                // Multi-cycle launch: nothing completes yet, so div_zero keeps its value.
                go      = 1'b1;
                done_d  = 1'b0;
                dz_d    = dz_q;
                sa_d    = a[WIDTH-1];
                neg_d   = a[WIDTH-1] ^ b[WIDTH-1];
                div_d   = (ALU_aluOp == ALU_DIV);
                state_d = StRun;
              end
            end
          endcase
          if (alu_wr) begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
          end
        end
      end
      StRun: begin
        if (core_finish) state_d = StFix;
      end
      StFix: begin
        if (div_q) begin
          hi_d     = rem_fix;
          lo_d     = quo_fix;
          result_d = quo_fix;
          zero_d   = (quo_fix == '0);
        end else begin
          hi_d     = prod_fix[2*WIDTH-1:WIDTH];
          lo_d     = prod_fix[WIDTH-1:0];
          result_d = prod_fix[WIDTH-1:0];
          zero_d   = (prod_fix[WIDTH-1:0] == '0);
        end
        dz_d    = 1'b0;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      result_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      sa_q     <= 1'b0;
      neg_q    <= 1'b0;
      div_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
      sa_q     <= sa_d;
      neg_q    <= neg_d;
      div_q    <= div_d;
    end
  end

  assign result   = result_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign zero     = zero_q;
  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (WIDTH=32): vector table for single-cycle
// ops plus hand-written MULT/DIV, handshake and reset-abort sequences.
module tb_alu_exec_unit;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic [W-1:0] result, hi, lo;
  logic         zero, busy, done, div_zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         z;
  } vec_t;

  vec_t tbl[9];

  alu_exec_unit #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ALU_aluOp (op),
    .a         (a),
    .b         (b),
    .result    (result),
    .hi        (hi),
    .lo        (lo),
    .zero      (zero),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string name, input logic [W-1:0] r, input logic [W-1:0] h,
                          input logic [W-1:0] l, input logic z, input logic dz);
    chk({name, ".result"}, result, r);
    chk({name, ".hi"}, hi, h);
    chk({name, ".lo"}, lo, l);
    chk({name, ".zero"}, 32'(zero), 32'(z));
    chk({name, ".div_zero"}, 32'(div_zero), 32'(dz));
  endtask

  // Start pulse for one cycle; returns 1 time unit after the start edge.
  task automatic apply(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges after the start edge until done, and busy cycles on the way.
  task automatic wait_done(input int inj, output int lat, output int bc);
    lat = 0;
    bc  = 0;
    while (!done && lat < 100) begin
      if (busy) bc++;
      if (lat == inj) begin
        start = 1'b1;
        op    = ALU_ADD;
        a     = 32'd1;
        b     = 32'd1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
    end
  endtask

  task automatic run_multi(input string name, input logic [2:0] o, input logic [W-1:0] x,
                           input logic [W-1:0] y, input int inj);
    int lat, bc;
    apply(o, x, y);
    wait_done(inj, lat, bc);
    chk({name, ".latency"}, lat, 33);
    chk({name, ".busy_cycles"}, bc, 33);
    chk({name, ".busy_at_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int nd;
    tbl[0] = '{ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0};
    tbl[1] = '{ALU_SUB, 32'd5,         32'd5,         32'h0000_0000, 1'b1};
    tbl[2] = '{ALU_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0};
    tbl[3] = '{ALU_SLT, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    tbl[4] = '{ALU_AND, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 1'b0};
    tbl[5] = '{ALU_OR,  32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FFF0, 1'b0};
    tbl[6] = '{ALU_NOP, 32'h0000_0001, 32'h0000_0002, 32'h0000_FFF0, 1'b0};
    tbl[7] = '{ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
    tbl[8] = '{ALU_SUB, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0};

    // Reset held with a simultaneous start request: reset wins.
    rst   = 1'b1;
    start = 1'b1;
    op    = ALU_ADD;
    a     = 32'd1;
    b     = 32'd1;
    repeat (3) @(posedge clk);
    #1;
    chk_outs("reset", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;

    for (int i = 0; i < 9; i++) begin
      apply(tbl[i].op, tbl[i].a, tbl[i].b);
      chk($sformatf("v%0d.done", i), 32'(done), 32'd1);
      chk($sformatf("v%0d.busy", i), 32'(busy), 32'd0);
      chk_outs($sformatf("v%0d", i), tbl[i].res, 32'd0, 32'd0, tbl[i].z, 1'b0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.done_fall", i), 32'(done), 32'd0);
    end

    run_multi("mult_n3x7", ALU_MULT, 32'hFFFF_FFFD, 32'd7, -1);
    chk_outs("mult_n3x7", 32'hFFFF_FFEB, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0);

    run_multi("div_n7d2", ALU_DIV, 32'hFFFF_FFF9, 32'd2, -1);
    chk_outs("div_n7d2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);

    apply(ALU_DIV, 32'd9, 32'd0);
    chk("div0.done", 32'(done), 32'd1);
    chk("div0.busy", 32'(busy), 32'd0);
    chk_outs("div0", 32'hFFFF_FFFF, 32'd9, 32'hFFFF_FFFF, 1'b0, 1'b1);

    // A plain ADD clears div_zero and leaves hi/lo alone.
    apply(ALU_ADD, 32'd2, 32'd3);
    chk_outs("add_after_div0", 32'd5, 32'd9, 32'hFFFF_FFFF, 1'b0, 1'b0);

    // Start during busy at cycle 5 must be ignored.
    run_multi("mult_6x7", ALU_MULT, 32'd6, 32'd7, 5);
    chk_outs("mult_6x7", 32'd42, 32'd0, 32'd42, 1'b0, 1'b0);

    // Back-to-back: start issued in the cycle done is high.
    apply(ALU_ADD, 32'd10, 32'd20);
    chk("b2b.done", 32'(done), 32'd1);
    chk_outs("b2b", 32'd30, 32'd0, 32'd42, 1'b0, 1'b0);

    run_multi("div_7dn2", ALU_DIV, 32'd7, 32'hFFFF_FFFE, -1);
    chk_outs("div_7dn2", 32'hFFFF_FFFD, 32'd1, 32'hFFFF_FFFD, 1'b0, 1'b0);

    run_multi("div_minneg", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    chk_outs("div_minneg", 32'h8000_0000, 32'd0, 32'h8000_0000, 1'b0, 1'b0);

    run_multi("mult_minneg", ALU_MULT, 32'h8000_0000, 32'h8000_0000, -1);
    chk_outs("mult_minneg", 32'd0, 32'h4000_0000, 32'd0, 1'b1, 1'b0);

    // Reset in the middle of a DIV aborts it without a done pulse.
    apply(ALU_DIV, 32'd100, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.done", 32'(done), 32'd0);
    chk_outs("abort", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    nd  = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) nd++;
    end
    chk("abort.no_done", nd, 32'd0);

    apply(ALU_ADD, 32'd1, 32'd1);
    chk("post_abort.done", 32'(done), 32'd1);
    chk_outs("post_abort", 32'd2, 32'd0, 32'd0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution-side consumer of the 3-bit ALU operation code produced by the ALU control decoder.
- Performs AND/OR/ADD/SUB/SLT in a single registered cycle.
- Performs signed MULT and DIV iteratively, one bit per cycle, writing HI/LO registers.
- Sits in the EX stage; a start/busy/done handshake lets the pipeline controller stall on multi-cycle ops.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4); MULT/DIV take WIDTH iterations.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- ALU_aluOp  input  3  operation code (encoding below)
- a  input  WIDTH  operand A (rs)
- b  input  WIDTH  operand B (rt)
- result  output  WIDTH  registered result; equals lo after MULT/DIV
- hi  output  WIDTH  MULT high word / DIV remainder
- lo  output  WIDTH  MULT low word / DIV quotient
- zero  output  1  registered flag, (result==0)
- busy  output  1  multi-cycle op in progress
- done  output  1  one-cycle pulse: operation complete, outputs valid
- div_zero  output  1  registered; set by DIV with b==0, cleared by any other completed op

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Opcodes: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT, 101 DIV, 110 NOP, 111 MULT.
- Reset: all outputs 0, state IDLE, counter 0.
  - Reset beats a simultaneous start.
  - Reset mid-MULT/DIV aborts: no done pulse; busy=0 and hi=lo=0 after the reset edge.
- FSM states: IDLE, RUN, FIX.
- IDLE, start=1, single-cycle op or NOP:
  - Outputs are updated at that edge; done=1 for exactly one cycle; state stays IDLE; busy stays 0.
  - ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
  - SLT is signed: result = {WIDTH-1 zeros, a<b}.
  - NOP: result, hi, lo, zero hold; done still pulses; div_zero clears.
- IDLE, start=1, DIV with b==0:
  - Single cycle: lo=result=all ones, hi=a, div_zero=1, done pulse.
- IDLE, start=1, MULT or DIV (b!=0):
  - Latch |a|, |b|, result sign and opcode; counter=0; go to RUN; busy=1.
- RUN:
  - One shift-add (MULT) or restoring shift-subtract (DIV) step per cycle.
  - After WIDTH steps (counter==WIDTH-1) go to FIX.
- FIX:
  - Apply sign correction: product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa (truncation toward zero).
  - Write hi/lo; result=lo; zero=(lo==0); div_zero=0; done=1; busy=0; return to IDLE.
- Latency:
  - Single-cycle ops: done 1 edge after the start edge.
  - MULT/DIV: done WIDTH+1 edges after the start edge (33 for WIDTH=32); busy is high for WIDTH+1 cycles and falls in the same cycle done rises.
- Handshake:
  - start while busy=1 is ignored with no side effects.
  - start in the cycle done is high is accepted normally (back-to-back).
- Corner cases:
  - Most-negative operand: magnitude taken as unsigned WIDTH bits; correct for MULT.
  - DIV of most-negative by -1 wraps: lo = most-negative, hi = 0.
- hi/lo change only on MULT, DIV, or reset.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams ALU_AND..ALU_MULT (shared with the ALU control decoder);
  - FSM state encoding;
  - WIDTH default.
- One natural sub-module: alu_muldiv_iter. It holds the iterative magnitude core with accumulator, shift registers and counter, and has an internal go/finish handshake. Top level keeps the FSM, single-cycle datapath, sign handling and output registers.

Test Plan:
- ADD 0x7FFFFFFF+0x00000001 -> result=0x80000000, zero=0, done 1 cycle after start; then SUB 5-5 -> result=0, zero=1.
- SLT a=0xFFFFFFFF, b=1 -> result=1; AND 0xF0F0,0x0FF0 -> 0x00F0; OR same -> 0xFFF0; NOP -> done pulses, result holds 0xFFF0.
- MULT a=-3, b=7 -> hi=0xFFFFFFFF, lo=result=0xFFFFFFEB, busy high 33 cycles, done exactly 33 edges after start.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, done at +33; then DIV a=9, b=0 -> lo=0xFFFFFFFF, hi=9, div_zero=1, done at +1.
- Start MULT 6*7; pulse start with ADD at cycle 5 -> ignored; done at +33 with lo=42, hi=0.
- Start DIV 100/3; assert rst at cycle 10 -> busy=0, hi=lo=0, no done; a following ADD 1+1 -> result=2, done at +1.
